// File: rtl/alu_board_pkg.sv
// Shared definitions for the 4-bit ALU board: widths, FSM state encoding,
// status-LED colours and the encoder step helpers.
// No ports (package).
package alu_board_pkg;

  localparam int OPW  = 4;  // operand width
  localparam int SELW = 3;  // opcode width
  localparam int RESW = 5;  // result width {flag, result[3:0]}

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ENTER_OP = 3'd2,
    EXEC     = 3'd3,
    SHOW     = 3'd4
  } state_t;

  // Colour codes packed as {r, g, b}
  localparam logic [2:0] COL_OFF   = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  function automatic logic [2:0] state_colour(input state_t s);
    logic [2:0] c;
    case (s)
      ENTER_A:  c = COL_GREEN;
      ENTER_B:  c = COL_RED;
      ENTER_OP: c = COL_BLUE;
      EXEC:     c = COL_OFF;
      SHOW:     c = COL_WHITE;
      default:  c = COL_OFF;
    endcase
    return c;
  endfunction

  // Simultaneous CW and CCW cancel out; wrap is the natural modulo of the width.
  function automatic logic [OPW-1:0] step_opnd(input logic [OPW-1:0] v,
                                               input logic cw, input logic ccw);
    logic [OPW-1:0] r;
    if (cw && !ccw)      r = v + 4'd1;
    else if (ccw && !cw) r = v - 4'd1;
    else                 r = v;
    return r;
  endfunction

  function automatic logic [SELW-1:0] step_sel(input logic [SELW-1:0] v,
                                               input logic cw, input logic ccw);
    logic [SELW-1:0] r;
    if (cw && !ccw)      r = v + 3'd1;
    else if (ccw && !cw) r = v - 3'd1;
    else                 r = v;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer. BTN is sampled once every DEB_CYCLES clocks; the
// stable level only follows two equal consecutive samples. PRESS pulses for
// one cycle after the stable level rises.
// Ports: CLK clock, RST sync active-high reset, BTN raw button (1 = pressed),
//        PRESS one-cycle press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESS
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          sample_r;
  logic          stable_r;
  logic          stable_d_r;

  // Sampling period counter, sample/stable registers and edge-detect delay
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r      <= '0;
      sample_r   <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
    end else begin
      stable_d_r <= stable_r;
      if (cnt_r == CNT_LAST) begin
        cnt_r    <= '0;
        sample_r <= BTN;
        if (BTN == sample_r) begin
          stable_r <= BTN;
        end else begin
          stable_r <= stable_r;
        end
      end else begin
        cnt_r    <= cnt_r + 1'b1;
        sample_r <= sample_r;
        stable_r <= stable_r;
      end
    end
  end

  // Built purely from registers, so the pulse is glitch-free
  assign PRESS = stable_r & ~stable_d_r;

endmodule

// File: rtl/alu_entry_ctrl.sv
// Operator-sequencing controller for the 4-bit ALU board. Encoder steps edit
// A, B and the opcode in turn; button presses advance ENTER_A -> ENTER_B ->
// ENTER_OP -> EXEC -> SHOW -> ENTER_A. RES/VALID are latched after the ALU
// has had SETTLE_CYCLES cycles to settle. All outputs are registered.
// Optional build macro AUTO_CYCLE_EN: SHOW auto-advances SEL and re-executes
// after AUTO_PERIOD cycles.
// Ports: CLK clock, RST sync active-high reset, STEP_CW/STEP_CCW encoder
//        pulses, BTN raw button, ALU_RES ALU result in; A, B, SEL to ALU;
//        RES latched result, VALID result matches A/B/SEL;
//        LED_R/LED_G/LED_B status LED bank.
module alu_entry_ctrl
  import alu_board_pkg::*;
#(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int SETTLE_CYCLES = 2
`ifdef AUTO_CYCLE_EN
  , parameter int AUTO_PERIOD = 50_000_000
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STEP_CW,
  input  logic            STEP_CCW,
  input  logic            BTN,
  input  logic [RESW-1:0] ALU_RES,
  output logic [OPW-1:0]  A,
  output logic [OPW-1:0]  B,
  output logic [SELW-1:0] SEL,
  output logic [RESW-1:0] RES,
  output logic            VALID,
  output logic [7:0]      LED_R,
  output logic [7:0]      LED_G,
  output logic [7:0]      LED_B
);

  localparam int SCW = (SETTLE_CYCLES < 4) ? 2 : $clog2(SETTLE_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  logic            press_s;
  state_t          state_r, state_nxt_s;
  logic [OPW-1:0]  a_r, a_nxt_s, b_r, b_nxt_s;
  logic [SELW-1:0] sel_r, sel_nxt_s;
  logic [RESW-1:0] res_r, res_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic [SCW-1:0]  settle_r, settle_nxt_s;
  logic [2:0]      col_nxt_s;
  logic [7:0]      led_red_r, led_grn_r, led_blu_r;
`ifdef AUTO_CYCLE_EN
  localparam int DWW = (AUTO_PERIOD < 4) ? 2 : $clog2(AUTO_PERIOD);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(AUTO_PERIOD - 1);
  logic [DWW-1:0]  dwell_r, dwell_nxt_s;
`endif

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN),
    .PRESS (press_s)
  );

  // Next-state and next-field logic; counters idle at zero outside their state
  always_comb begin
    state_nxt_s  = state_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    sel_nxt_s    = sel_r;
    res_nxt_s    = res_r;
    valid_nxt_s  = valid_r;
    settle_nxt_s = '0;
`ifdef AUTO_CYCLE_EN
    dwell_nxt_s  = '0;
`endif
    case (state_r)
      ENTER_A: begin
        a_nxt_s = step_opnd(a_r, STEP_CW, STEP_CCW);
        if (press_s) state_nxt_s = ENTER_B;
        else         state_nxt_s = ENTER_A;
      end
      ENTER_B: begin
        b_nxt_s = step_opnd(b_r, STEP_CW, STEP_CCW);
        if (press_s) state_nxt_s = ENTER_OP;
        else         state_nxt_s = ENTER_B;
      end
      ENTER_OP: begin
        sel_nxt_s = step_sel(sel_r, STEP_CW, STEP_CCW);
        if (press_s) state_nxt_s = EXEC;
        else         state_nxt_s = ENTER_OP;
      end
      EXEC: begin
        // ALU_RES is sampled on the last settle cycle, together with SHOW entry
        if (settle_r == SETTLE_LAST) begin
          res_nxt_s   = ALU_RES;
          valid_nxt_s = 1'b1;
          state_nxt_s = SHOW;
        end else begin
          settle_nxt_s = settle_r + 1'b1;
          state_nxt_s  = EXEC;
        end
      end
      SHOW: begin
        if (press_s) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = ENTER_A;
        end else begin
`ifdef AUTO_CYCLE_EN
          if (dwell_r == DWELL_LAST) begin
            sel_nxt_s   = sel_r + 3'd1;
            valid_nxt_s = 1'b0;
            state_nxt_s = EXEC;
          end else begin
            dwell_nxt_s = dwell_r + 1'b1;
            state_nxt_s = SHOW;
          end
`else
          state_nxt_s = SHOW;
`endif
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ENTER_A;
      end
    endcase
    col_nxt_s = state_colour(state_nxt_s);
  end

  // State, fields and LED registers; LEDs are built from next values so they
  // line up with the state they describe
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ENTER_A;
      a_r       <= 4'd0;
      b_r       <= 4'd0;
      sel_r     <= 3'd0;
      res_r     <= 5'd0;
      valid_r   <= 1'b0;
      settle_r  <= '0;
      led_red_r <= 8'd0;
      led_grn_r <= 8'd0;
      led_blu_r <= 8'd0;
`ifdef AUTO_CYCLE_EN
      dwell_r   <= '0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      a_r       <= a_nxt_s;
      b_r       <= b_nxt_s;
      sel_r     <= sel_nxt_s;
      res_r     <= res_nxt_s;
      valid_r   <= valid_nxt_s;
      settle_r  <= settle_nxt_s;
      led_red_r <= {col_nxt_s[2], 7'd0};
      led_grn_r <= {col_nxt_s[1], 2'b00, (valid_nxt_s ? res_nxt_s : 5'd0)};
      led_blu_r <= {col_nxt_s[0], 4'd0, sel_nxt_s};
`ifdef AUTO_CYCLE_EN
      dwell_r   <= dwell_nxt_s;
`endif
    end
  end

  assign A     = a_r;
  assign B     = b_r;
  assign SEL   = sel_r;
  assign RES   = res_r;
  assign VALID = valid_r;
  assign LED_R = led_red_r;
  assign LED_G = led_grn_r;
  assign LED_B = led_blu_r;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Self-checking bench for alu_entry_ctrl (DEB_CYCLES=4, SETTLE_CYCLES=2).
module tb_alu_entry_ctrl;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       STEP_CW = 1'b0;
  logic       STEP_CCW = 1'b0;
  logic       BTN = 1'b0;
  logic [4:0] ALU_RES;
  logic [3:0] A, B;
  logic [2:0] SEL;
  logic [4:0] RES;
  logic       VALID;
  logic [7:0] LED_R, LED_G, LED_B;

  int checks = 0;
  int errors = 0;

  // Reference debouncer state, advanced by tick()
  int   m_cnt = 0;
  logic m_samp = 1'b0;
  logic m_stab = 1'b0;
  logic m_stab_d = 1'b0;
  logic m_press;
  assign m_press = m_stab & ~m_stab_d;

  typedef struct {
    logic       cw;
    logic       ccw;
    logic [3:0] exp_a;
  } vec_t;
  vec_t vecs[25];

  always #5 CLK = ~CLK;

  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
    logic [4:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      default: r = {1'b0, ~a};
    endcase
    return r;
  endfunction

  assign ALU_RES = alu_model(A, B, SEL);

  alu_entry_ctrl #(
    .DEB_CYCLES    (DEB),
    .SETTLE_CYCLES (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .STEP_CW  (STEP_CW),
    .STEP_CCW (STEP_CCW),
    .BTN      (BTN),
    .ALU_RES  (ALU_RES),
    .A        (A),
    .B        (B),
    .SEL      (SEL),
    .RES      (RES),
    .VALID    (VALID),
    .LED_R    (LED_R),
    .LED_G    (LED_G),
    .LED_B    (LED_B)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock edge; the debouncer reference sees the same BTN/RST as the DUT
  task automatic tick();
    if (RST) begin
      m_cnt = 0; m_samp = 1'b0; m_stab = 1'b0; m_stab_d = 1'b0;
    end else begin
      m_stab_d = m_stab;
      if (m_cnt == DEB - 1) begin
        if (BTN == m_samp) m_stab = BTN;
        m_samp = BTN;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Holds BTN until the edge on which the FSM sees PRESS, applying the given
  // step on exactly that edge; BTN is left high
  task automatic do_press(input logic cw, input logic ccw);
    bit found = 1'b0;
    BTN = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_press) begin
        STEP_CW = cw; STEP_CCW = ccw;
        tick();
        STEP_CW = 1'b0; STEP_CCW = 1'b0;
        found = 1'b1;
      end else begin
        tick();
      end
    end
    chk("press_seen", int'(found), 1);
  endtask

  task automatic release_btn();
    BTN = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    // Step table for ENTER_A: 3 CCW, 16 CW, CW+CCW, 4 CCW, idle
    vecs[0] = '{1'b0, 1'b1, 4'd15};
    vecs[1] = '{1'b0, 1'b1, 4'd14};
    vecs[2] = '{1'b0, 1'b1, 4'd13};
    for (int i = 0; i < 16; i++) vecs[3+i] = '{1'b1, 1'b0, 4'((14 + i) % 16)};
    vecs[19] = '{1'b1, 1'b1, 4'd13};
    vecs[20] = '{1'b0, 1'b1, 4'd12};
    vecs[21] = '{1'b0, 1'b1, 4'd11};
    vecs[22] = '{1'b0, 1'b1, 4'd10};
    vecs[23] = '{1'b0, 1'b1, 4'd9};
    vecs[24] = '{1'b0, 1'b0, 4'd9};

    // 1. Reset
    RST = 1'b1;
    tick(); tick();
    chk("rst_a", int'(A), 0);
    chk("rst_b", int'(B), 0);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_res", int'(RES), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_led_r", int'(LED_R), 0);
    chk("rst_led_g", int'(LED_G), 0);
    chk("rst_led_b", int'(LED_B), 0);
    RST = 1'b0;
    tick();
    chk("enter_a_led_g", int'(LED_G), 8'h80);
    chk("enter_a_led_r", int'(LED_R), 0);
    chk("enter_a_led_b", int'(LED_B), 0);

    // 2. Step / wrap table
    for (int i = 0; i < 25; i++) begin
      STEP_CW = vecs[i].cw; STEP_CCW = vecs[i].ccw;
      tick();
      chk($sformatf("step_a[%0d]", i), int'(A), int'(vecs[i].exp_a));
    end
    STEP_CW = 1'b0; STEP_CCW = 1'b0;
    chk("step_b_untouched", int'(B), 0);

    // 3. Bouncing button gives one advance
    for (int i = 0; i < 6; i++) begin
      BTN = (i % 2 == 0);
      tick();
    end
    BTN = 1'b1;
    repeat (12) tick();
    chk("bounce_led_r", int'(LED_R), 8'h80);
    chk("bounce_led_g", int'(LED_G), 0);
    release_btn();
    chk("bounce_single_led_r", int'(LED_R), 8'h80);
    STEP_CW = 1'b1;
    repeat (8) tick();
    STEP_CW = 1'b0;
    chk("b_value", int'(B), 8);
    chk("a_kept", int'(A), 9);

    // 4. Full operation 9 + 8 with SEL=0
    do_press(1'b0, 1'b0);
    chk("op_led_b", int'(LED_B), 8'h80);
    release_btn();
    do_press(1'b0, 1'b0);
    chk("exec_led_r", int'(LED_R), 0);
    chk("exec_led_g", int'(LED_G), 0);
    chk("exec_led_b", int'(LED_B), 0);
    chk("exec_valid0", int'(VALID), 0);
    STEP_CW = 1'b1;
    tick();
    STEP_CW = 1'b0;
    chk("exec_valid1", int'(VALID), 0);
    chk("exec_step_ignored", int'(A), 9);
    tick();
    chk("show_valid", int'(VALID), 1);
    chk("show_res", int'(RES), 17);
    chk("show_led_g", int'(LED_G), 8'h91);
    chk("show_led_r", int'(LED_R), 8'h80);
    chk("show_led_b", int'(LED_B), 8'h80);
    STEP_CW = 1'b1;
    tick();
    STEP_CW = 1'b0;
    chk("show_step_ignored", int'(SEL), 0);
    release_btn();
    chk("show_holds", int'(VALID), 1);
    do_press(1'b0, 1'b0);
    chk("leave_valid", int'(VALID), 0);
    chk("leave_res_kept", int'(RES), 17);
    chk("leave_a_kept", int'(A), 9);
    chk("leave_led_g", int'(LED_G), 8'h80);
    release_btn();

    // 5. Step and press coincide in ENTER_OP with SEL=7
    do_press(1'b0, 1'b0);
    release_btn();
    do_press(1'b0, 1'b0);
    release_btn();
    STEP_CCW = 1'b1;
    tick();
    STEP_CCW = 1'b0;
    chk("sel_wrap_down", int'(SEL), 7);
    chk("sel_led_b", int'(LED_B), 8'h87);
    do_press(1'b1, 1'b0);
    chk("coincide_sel", int'(SEL), 0);
    chk("coincide_exec_led_b", int'(LED_B), 0);
    chk("coincide_exec_led_g", int'(LED_G), 0);
    chk("coincide_exec_led_r", int'(LED_R), 0);

    // 6. Reset in the middle of EXEC
    BTN = 1'b0;
    RST = 1'b1;
    tick();
    chk("mid_rst_res", int'(RES), 0);
    chk("mid_rst_valid", int'(VALID), 0);
    chk("mid_rst_a", int'(A), 0);
    chk("mid_rst_b", int'(B), 0);
    chk("mid_rst_led_r", int'(LED_R), 0);
    RST = 1'b0;
    tick();
    chk("post_rst_led_g", int'(LED_G), 8'h80);
    STEP_CW = 1'b1;
    tick();
    STEP_CW = 1'b0;
    chk("post_rst_step_a", int'(A), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
